// File: rtl/uart_rx_cmd_decoder.sv
// Byte-level command decoder behind the UART receiver: walks the write, read and ALU frames.
// It issues single-cycle register-file and ALU strobes. Bytes with parity or stop errors abort the frame.
module uart_rx_cmd_decoder #(
   parameter int unsigned           DATA_WIDTH  = 8,
   parameter int unsigned           ADDR_WIDTH  = 4,
   parameter int unsigned           FUN_WIDTH   = 4,
   parameter logic [DATA_WIDTH-1:0] CMD_WR      = 8'hAA,
   parameter logic [DATA_WIDTH-1:0] CMD_RD      = 8'hBB,
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 8'hCC,
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP = 8'hDD,
   parameter int unsigned           OPA_ADDR    = 0,
   parameter int unsigned           OPB_ADDR    = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic                  RX_PAR_ERR,
   input  logic                  RX_STP_ERR,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WrData,
   output logic                  ALU_EN,
   output logic [FUN_WIDTH-1:0]  ALU_FUN,
   output logic                  busy,
   output logic                  frm_err,
   output logic                  cmd_err
);

   typedef enum logic [2:0] {
      StIdle,
      StWrAddr,
      StWrData,
      StRdAddr,
      StAluA,
      StAluB,
      StAluFun
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_lat_q, addr_lat_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic                  alu_en_q, alu_en_d;
   logic                  busy_q, busy_d;
   logic                  frm_err_q, frm_err_d;
   logic                  cmd_err_q, cmd_err_d;
   logic                  byte_err;

   assign byte_err = RX_PAR_ERR | RX_STP_ERR;

   always_comb begin
      state_d    = state_q;
      addr_lat_d = addr_lat_q;
      address_d  = address_q;
      wr_data_d  = wr_data_q;
      alu_fun_d  = alu_fun_q;
      wr_en_d    = 1'b0;
      rd_en_d    = 1'b0;
      alu_en_d   = 1'b0;
      frm_err_d  = 1'b0;
      cmd_err_d  = 1'b0;

      if (RX_D_VLD && byte_err) begin
         // Partial frames are dropped as-is; operands already written stay written.
         frm_err_d = 1'b1;
         state_d   = StIdle;
      end else if (RX_D_VLD) begin
         unique case (state_q)
            StIdle: begin
               if (RX_P_DATA == CMD_WR) begin
                  state_d = StWrAddr;
               end else if (RX_P_DATA == CMD_RD) begin
                  state_d = StRdAddr;
               end else if (RX_P_DATA == CMD_ALU_OP) begin
                  state_d = StAluA;
               end else if (RX_P_DATA == CMD_ALU_NOP) begin
                  state_d = StAluFun;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            StWrAddr: begin
               addr_lat_d = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d    = StWrData;
            end
            StWrData: begin
               wr_en_d   = 1'b1;
               address_d = addr_lat_q;
               wr_data_d = RX_P_DATA;
               state_d   = StIdle;
            end
            StRdAddr: begin
               rd_en_d   = 1'b1;
               address_d = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d   = StIdle;
            end
            StAluA: begin
               wr_en_d   = 1'b1;
               address_d = ADDR_WIDTH'(OPA_ADDR);
               wr_data_d = RX_P_DATA;
               state_d   = StAluB;
            end
            StAluB: begin
               wr_en_d   = 1'b1;
               address_d = ADDR_WIDTH'(OPB_ADDR);
               wr_data_d = RX_P_DATA;
               state_d   = StAluFun;
            end
            StAluFun: begin
               alu_en_d  = 1'b1;
               alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
               state_d   = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end

      // Registered from next state so busy drops together with the final strobe.
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= StIdle;
         addr_lat_q <= '0;
         address_q  <= '0;
         wr_data_q  <= '0;
         alu_fun_q  <= '0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         alu_en_q   <= 1'b0;
         busy_q     <= 1'b0;
         frm_err_q  <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_lat_q <= addr_lat_d;
         address_q  <= address_d;
         wr_data_q  <= wr_data_d;
         alu_fun_q  <= alu_fun_d;
         wr_en_q    <= wr_en_d;
         rd_en_q    <= rd_en_d;
         alu_en_q   <= alu_en_d;
         busy_q     <= busy_d;
         frm_err_q  <= frm_err_d;
         cmd_err_q  <= cmd_err_d;
      end
   end

   assign WrEn    = wr_en_q;
   assign RdEn    = rd_en_q;
   assign Address = address_q;
   assign WrData  = wr_data_q;
   assign ALU_EN  = alu_en_q;
   assign ALU_FUN = alu_fun_q;
   assign busy    = busy_q;
   assign frm_err = frm_err_q;
   assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Bench for uart_rx_cmd_decoder: directed protocol cases plus random byte streams.
// Every cycle is checked against a frame-queue model of the command protocol.
module tb_uart_rx_cmd_decoder;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] RX_P_DATA = 8'h00;
   logic       RX_D_VLD = 1'b0;
   logic       RX_PAR_ERR = 1'b0;
   logic       RX_STP_ERR = 1'b0;
   logic       WrEn, RdEn, ALU_EN, busy, frm_err, cmd_err;
   logic [3:0] Address, ALU_FUN;
   logic [7:0] WrData;

   int nvec = 0;
   int nerr = 0;

   // Model state: the accepted bytes of the frame in progress, command first.
   logic [7:0] fq[$];
   logic       e_wr, e_rd, e_alu, e_busy, e_frm, e_cmd;
   logic [3:0] e_addr, e_fun;
   logic [7:0] e_wdata;

   uart_rx_cmd_decoder dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_P_DATA  (RX_P_DATA),
      .RX_D_VLD   (RX_D_VLD),
      .RX_PAR_ERR (RX_PAR_ERR),
      .RX_STP_ERR (RX_STP_ERR),
      .WrEn       (WrEn),
      .RdEn       (RdEn),
      .Address    (Address),
      .WrData     (WrData),
      .ALU_EN     (ALU_EN),
      .ALU_FUN    (ALU_FUN),
      .busy       (busy),
      .frm_err    (frm_err),
      .cmd_err    (cmd_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      {e_wr, e_rd, e_alu, e_busy, e_frm, e_cmd} = '0;
      e_addr  = '0;
      e_fun   = '0;
      e_wdata = '0;
   endtask

   task automatic check_all();
      chk("WrEn", 32'(WrEn), 32'(e_wr));
      chk("RdEn", 32'(RdEn), 32'(e_rd));
      chk("ALU_EN", 32'(ALU_EN), 32'(e_alu));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("frm_err", 32'(frm_err), 32'(e_frm));
      chk("cmd_err", 32'(cmd_err), 32'(e_cmd));
      chk("Address", 32'(Address), 32'(e_addr));
      chk("WrData", 32'(WrData), 32'(e_wdata));
      chk("ALU_FUN", 32'(ALU_FUN), 32'(e_fun));
   endtask

   // One clock: drive a byte (or idle), predict the outputs, compare after the edge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic pe, input logic se);
      logic [7:0] b1;
      RX_D_VLD   = v;
      RX_P_DATA  = d;
      RX_PAR_ERR = pe;
      RX_STP_ERR = se;
      {e_wr, e_rd, e_alu, e_frm, e_cmd} = '0;
      if (v) begin
         if (pe || se) begin
            e_frm = 1'b1;
            fq.delete();
         end else if (fq.size() == 0) begin
            if (d inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) fq.push_back(d);
            else e_cmd = 1'b1;
         end else begin
            fq.push_back(d);
            b1 = fq[1];
            case (fq[0])
               8'hAA: if (fq.size() == 3) begin
                  e_wr = 1'b1; e_addr = b1[3:0]; e_wdata = d; fq.delete();
               end
               8'hBB: begin
                  e_rd = 1'b1; e_addr = d[3:0]; fq.delete();
               end
               8'hCC: begin
                  if (fq.size() == 2) begin
                     e_wr = 1'b1; e_addr = 4'd0; e_wdata = d;
                  end else if (fq.size() == 3) begin
                     e_wr = 1'b1; e_addr = 4'd1; e_wdata = d;
                  end else begin
                     e_alu = 1'b1; e_fun = d[3:0]; fq.delete();
                  end
               end
               default: begin
                  e_alu = 1'b1; e_fun = d[3:0]; fq.delete();
               end
            endcase
         end
      end
      e_busy = (fq.size() != 0);
      @(posedge CLK);
      #1;
      RX_D_VLD = 1'b0;
      check_all();
   endtask

   task automatic send(input logic [7:0] d);
      cycle(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic pin_outputs_zero(input string tag);
      chk({tag, "_zero"}, 32'({WrEn, RdEn, ALU_EN, busy, frm_err, cmd_err, Address, WrData,
                                ALU_FUN}), 32'd0);
   endtask

   initial begin
      model_reset();
      #1 RST = 1'b1;
      #3;
      pin_outputs_zero("reset");
      @(posedge CLK);
      #1 RST = 1'b0;
      idle();

      // Write with idle gaps between bytes
      send(8'hAA); chk("wr_busy1", 32'(busy), 1);
      idle();
      send(8'h05); idle();
      send(8'h3C);
      chk("wr_en", 32'(WrEn), 1);
      chk("wr_addr", 32'(Address), 5);
      chk("wr_data", 32'(WrData), 32'h3C);
      chk("wr_busy_end", 32'(busy), 0);
      idle();

      // Read with address truncation
      send(8'hBB); send(8'hF7);
      chk("rd_en", 32'(RdEn), 1);
      chk("rd_addr", 32'(Address), 7);

      // ALU with operands, back to back
      send(8'hCC); send(8'h12);
      chk("opa_addr", 32'(Address), 0);
      chk("opa_data", 32'(WrData), 32'h12);
      send(8'h34);
      chk("opb_addr", 32'(Address), 1);
      chk("opb_data", 32'(WrData), 32'h34);
      send(8'h09);
      chk("alu_en", 32'(ALU_EN), 1);
      chk("alu_fun", 32'(ALU_FUN), 9);

      // Unknown command, then ALU without operands
      send(8'h55);
      chk("cmd_err", 32'(cmd_err), 1);
      send(8'hDD); send(8'h02);
      chk("nop_fun", 32'(ALU_FUN), 2);

      // Error mid-frame, then a clean retry, then error on the command byte
      send(8'hAA); send(8'h03);
      cycle(1'b1, 8'h11, 1'b1, 1'b0);
      chk("par_frm", 32'(frm_err), 1);
      chk("par_nowr", 32'(WrEn), 0);
      send(8'hAA); send(8'h03); send(8'h11);
      chk("retry_addr", 32'(Address), 3);
      chk("retry_data", 32'(WrData), 32'h11);
      cycle(1'b1, 8'hAA, 1'b0, 1'b1);
      chk("stp_frm", 32'(frm_err), 1);
      chk("stp_busy", 32'(busy), 0);

      // Command code inside a frame is data
      send(8'hAA); send(8'hBB); send(8'hCC);
      chk("cmd_as_data", 32'(WrData), 32'hCC);

      // Reset mid-frame
      send(8'hCC); send(8'h12);
      RST = 1'b1;
      #2;
      pin_outputs_zero("midreset");
      model_reset();
      @(posedge CLK);
      #1 RST = 1'b0;
      send(8'h34);
      chk("rst_cmd1", 32'(cmd_err), 1);
      send(8'h09);
      chk("rst_cmd2", 32'(cmd_err), 1);
      chk("rst_noalu", 32'(ALU_EN), 0);

      // Random byte stream biased toward valid frames
      for (int i = 0; i < 3000; i++) begin
         logic       v, pe, se;
         logic [7:0] d;
         v  = ($urandom_range(0, 9) < 7);
         pe = ($urandom_range(0, 29) == 0);
         se = ($urandom_range(0, 29) == 0);
         case ($urandom_range(0, 9))
            0: d = 8'hAA;
            1: d = 8'hBB;
            2: d = 8'hCC;
            3: d = 8'hDD;
            default: d = 8'($urandom);
         endcase
         cycle(v, d, pe, se);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/uart_rx_cmd_decoder.md
# uart_rx_cmd_decoder

Frame-level command decoder sitting directly downstream of the UART receiver. It consumes each received byte (`RX_P_DATA` qualified by `RX_D_VLD`) and walks a multi-byte command protocol. It issues single-cycle register-file write/read strobes and ALU-start strobes to the system side. Bytes flagged with a parity or stop error abort the frame in progress.

## Interface
- `DATA_WIDTH`, 8, received byte width and write-data width
- `ADDR_WIDTH`, 4, register-file address width; the address byte is truncated to LSBs
- `FUN_WIDTH`, 4, ALU function width; the function byte is truncated to LSBs
- `CMD_WR`, 8'hAA, register write command: CMD, ADDR, DATA
- `CMD_RD`, 8'hBB, register read command: CMD, ADDR
- `CMD_ALU_OP`, 8'hCC, ALU with operands: CMD, A, B, FUN
- `CMD_ALU_NOP`, 8'hDD, ALU without operands: CMD, FUN
- `OPA_ADDR`, 0, register address that receives operand A
- `OPB_ADDR`, 1, register address that receives operand B

Ports:
- `CLK`  in  1  system clock
- `RST`  in  1  asynchronous, active-high reset
- `RX_P_DATA`  in  DATA_WIDTH  received byte; valid only while `RX_D_VLD`=1
- `RX_D_VLD`  in  1  one-cycle byte-valid pulse
- `RX_PAR_ERR`  in  1  parity error for the current byte, sampled with `RX_D_VLD`
- `RX_STP_ERR`  in  1  stop error for the current byte, sampled with `RX_D_VLD`
- `WrEn`  out  1  register write strobe, one cycle
- `RdEn`  out  1  register read strobe, one cycle
- `Address`  out  ADDR_WIDTH  register address, valid with `WrEn`/`RdEn`
- `WrData`  out  DATA_WIDTH  write data, valid with `WrEn`
- `ALU_EN`  out  1  ALU start strobe, one cycle
- `ALU_FUN`  out  FUN_WIDTH  ALU function, valid with `ALU_EN`
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE)
- `frm_err`  out  1  one-cycle pulse: a byte was dropped due to parity or stop error
- `cmd_err`  out  1  one-cycle pulse: an unknown command byte was received in IDLE

## Operation
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN.
- A byte is "accepted" when `RX_D_VLD`=1 and `RX_PAR_ERR`=`RX_STP_ERR`=0. All transitions happen only on an accepted byte or an error byte.
- Transitions from IDLE:
  - `CMD_WR` → WR_ADDR
  - `CMD_RD` → RD_ADDR
  - `CMD_ALU_OP` → ALU_A
  - `CMD_ALU_NOP` → ALU_FUN
  - any other byte: stay in IDLE, pulse `cmd_err`
- WR_ADDR: latch the address (low ADDR_WIDTH bits) into an internal register → WR_DATA.
- WR_DATA: `WrEn`=1, `Address`=latched address, `WrData`=byte → IDLE.
- RD_ADDR: `RdEn`=1, `Address`=byte LSBs → IDLE.
- ALU_A: `WrEn`=1, `Address`=OPA_ADDR, `WrData`=byte → ALU_B.
- ALU_B: `WrEn`=1, `Address`=OPB_ADDR, `WrData`=byte → ALU_FUN.
- ALU_FUN: `ALU_EN`=1, `ALU_FUN`=byte LSBs → IDLE.
- Error byte (`RX_D_VLD`=1 with either error flag set), in any state:
  - byte is discarded
  - `frm_err` pulses
  - state → IDLE; no strobe is issued for that byte
  - any partially executed frame is not rolled back (an operand A already written stays written)
- Command codes are decoded only in IDLE. Inside a frame, a byte equal to a command code is treated as data.
- No timeout: a frame waits indefinitely for its next byte.

## Timing
- All outputs are registered.
- Strobes (`WrEn`, `RdEn`, `ALU_EN`, `frm_err`, `cmd_err`) assert exactly one cycle after the `RX_D_VLD` cycle and last one cycle.
- `Address`, `WrData`, `ALU_FUN` are valid in the strobe cycle and hold their value until the next strobe.
- `busy` rises the cycle after an accepted command byte. It falls the same cycle the final strobe asserts.
- Back-to-back `RX_D_VLD` on consecutive cycles must be handled without loss. There is no backpressure; downstream must accept each strobe.
- Reset values: every output is 0; state = IDLE; latched address = 0.
- Reset asserted mid-frame: frame is abandoned immediately; no strobe is issued after reset deassertion until a new command arrives.

## Test plan
- Write: bytes AA, 05, 3C → one `WrEn` pulse with `Address`=5, `WrData`=3C; `busy` high over 2 byte gaps; no other strobes.
- Read and truncation: BB, F7 → `RdEn` pulse with `Address`=7 (ADDR_WIDTH=4).
- ALU with operands: CC, 12, 34, 09 sent on consecutive cycles → `WrEn` (0, 12), then `WrEn` (1, 34), then `ALU_EN` with `ALU_FUN`=9; each strobe one cycle after its byte.
- Unknown command: 55 → `cmd_err` pulse, state stays IDLE. Then DD, 02 → `ALU_EN` with `ALU_FUN`=2.
- Error mid-frame: AA, 03, then data byte with `RX_PAR_ERR`=1 → `frm_err` pulse, no `WrEn`. Then AA, 03, 11 → `WrEn` (3, 11). Repeat with `RX_STP_ERR`=1 on the command byte → `frm_err`, no state change.
- Reset: assert `RST` after CC, 12 → all outputs 0 immediately. After release, bytes 34, 09 → two `cmd_err` pulses (34 and 09 are not commands) and no `WrEn`/`ALU_EN`.
